// File: rtl/mac_seq_ctrl.sv
// mac_seq_ctrl: issue/response sequencer between the execute stage and the two-stage 33x33 MAC.
// Define MAC_SEQ_PERF_EN to build the perf_ops/perf_stalls counters (constant 0 otherwise).
module mac_seq_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pause,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_op,
    input  logic             req_sgn1,
    input  logic             req_sgn2,
    input  logic [31:0]      req_rs1,
    input  logic [31:0]      req_rs2,
    input  logic [4:0]       req_tag,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_lo,
    output logic [31:0]      rsp_hi,
    output logic [4:0]       rsp_tag,
    output logic             rsp_err,
    output logic             mac_pause,
    output logic             mac_mul_en,
    output logic             mac_low,
    output logic             mac_high,
    output logic [32:0]      mac_din1,
    output logic [32:0]      mac_din2,
    input  logic [31:0]      mac_dlout,
    input  logic [31:0]      mac_dhout,
    input  logic             mac_vhdout,
    output logic [CNT_W-1:0] perf_ops,
    output logic [CNT_W-1:0] perf_stalls
);

    localparam logic [2:0] OP_MUL   = 3'd0;
    localparam logic [2:0] OP_MACL  = 3'd1;
    localparam logic [2:0] OP_MACH  = 3'd2;
    localparam logic [2:0] OP_MACLH = 3'd3;
    localparam logic [2:0] OP_CLR   = 3'd4;
    localparam logic [2:0] OP_READ  = 3'd5;

    logic dec_mul, dec_low, dec_high, dec_zero, dec_rsvd;
    logic accept, stall, s2_fire;

    logic        s2_valid_q, s2_valid_d;
    logic [31:0] s2_lo_q, s2_lo_d;
    logic        s2_high_q, s2_high_d;
    logic [4:0]  s2_tag_q, s2_tag_d;
    logic        s2_err_q, s2_err_d;

    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_lo_q, rsp_lo_d;
    logic [31:0] rsp_hi_q, rsp_hi_d;
    logic [4:0]  rsp_tag_q, rsp_tag_d;
    logic        rsp_err_q, rsp_err_d;

    always_comb begin : op_decode
        dec_mul  = 1'b0;
        dec_low  = 1'b0;
        dec_high = 1'b0;
        dec_zero = 1'b0;
        dec_rsvd = 1'b0;
        case (req_op)
            OP_MUL:   begin dec_mul = 1'b1; dec_low = 1'b1; dec_high = 1'b1; end
            OP_MACL:  dec_low = 1'b1;
            OP_MACH:  dec_high = 1'b1;
            OP_MACLH: begin dec_low = 1'b1; dec_high = 1'b1; end
            OP_CLR:   begin dec_mul = 1'b1; dec_low = 1'b1; dec_high = 1'b1; dec_zero = 1'b1; end
            OP_READ:  begin dec_low = 1'b1; dec_high = 1'b1; dec_zero = 1'b1; end
            default:  dec_rsvd = 1'b1;
        endcase
    end

    // Handshake: a request transfers in a cycle with req_valid & req_ready, a response is held
    // stable from rsp_valid until a cycle with rsp_valid & rsp_ready; req_ready ignores req_valid.
    assign stall     = s2_valid_q & rsp_valid_q & ~rsp_ready;
    assign mac_pause = pause | stall;
    assign req_ready = ~mac_pause;
    assign accept    = req_valid & req_ready;
    assign s2_fire   = s2_valid_q & ~mac_pause;

    assign mac_din1   = dec_zero ? 33'd0 : {req_sgn1 & req_rs1[31], req_rs1};
    assign mac_din2   = dec_zero ? 33'd0 : {req_sgn2 & req_rs2[31], req_rs2};
    assign mac_mul_en = accept & dec_mul;
    assign mac_low    = accept & dec_low;
    assign mac_high   = accept & dec_high;

    // S2 and the MAC freeze together, so mac_dhout still belongs to the S2 op when it resumes.
    always_comb begin : s2_next
        s2_valid_d = s2_valid_q;
        s2_lo_d    = s2_lo_q;
        s2_high_d  = s2_high_q;
        s2_tag_d   = s2_tag_q;
        s2_err_d   = s2_err_q;
        if (!mac_pause) begin
            s2_valid_d = accept;
            s2_lo_d    = mac_low ? mac_dlout : 32'd0;
            s2_high_d  = mac_high;
            s2_tag_d   = req_tag;
            s2_err_d   = accept & dec_rsvd;
        end
    end

    always_comb begin : rsp_next
        rsp_valid_d = rsp_valid_q;
        rsp_lo_d    = rsp_lo_q;
        rsp_hi_d    = rsp_hi_q;
        rsp_tag_d   = rsp_tag_q;
        rsp_err_d   = rsp_err_q;
        if (s2_fire) begin
            rsp_valid_d = 1'b1;
            rsp_lo_d    = s2_lo_q;
            rsp_hi_d    = s2_high_q ? mac_dhout : 32'd0;
            rsp_tag_d   = s2_tag_q;
            rsp_err_d   = s2_err_q;
        end else if (rsp_ready) begin
            rsp_valid_d = 1'b0;
            rsp_lo_d    = 32'd0;
            rsp_hi_d    = 32'd0;
            rsp_tag_d   = 5'd0;
            rsp_err_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s2_valid_q  <= 1'b0;
            s2_lo_q     <= 32'd0;
            s2_high_q   <= 1'b0;
            s2_tag_q    <= 5'd0;
            s2_err_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_lo_q    <= 32'd0;
            rsp_hi_q    <= 32'd0;
            rsp_tag_q   <= 5'd0;
            rsp_err_q   <= 1'b0;
        end else begin
            s2_valid_q  <= s2_valid_d;
            s2_lo_q     <= s2_lo_d;
            s2_high_q   <= s2_high_d;
            s2_tag_q    <= s2_tag_d;
            s2_err_q    <= s2_err_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_lo_q    <= rsp_lo_d;
            rsp_hi_q    <= rsp_hi_d;
            rsp_tag_q   <= rsp_tag_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_lo    = rsp_lo_q;
    assign rsp_hi    = rsp_hi_q;
    assign rsp_tag   = rsp_tag_q;
    assign rsp_err   = rsp_err_q;

`ifdef MAC_SEQ_PERF_EN
    logic [CNT_W-1:0] perf_ops_q, perf_ops_d;
    logic [CNT_W-1:0] perf_stalls_q, perf_stalls_d;

    always_comb begin : perf_next
        perf_ops_d    = perf_ops_q + {{(CNT_W-1){1'b0}}, accept & ~dec_rsvd};
        perf_stalls_d = perf_stalls_q + {{(CNT_W-1){1'b0}}, stall};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_ops_q    <= '0;
            perf_stalls_q <= '0;
        end else begin
            perf_ops_q    <= perf_ops_d;
            perf_stalls_q <= perf_stalls_d;
        end
    end

    assign perf_ops    = perf_ops_q;
    assign perf_stalls = perf_stalls_q;
`else
    assign perf_ops    = '0;
    assign perf_stalls = '0;
`endif

    // The high-half valid flag is redundant: S2 already knows whether its op strobed mac_high.
    logic unused_vhdout;
    assign unused_vhdout = mac_vhdout;

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// tb_mac_seq_ctrl: vector table, multi-cycle corner sequences and randomized traffic for
// mac_seq_ctrl, with a behavioural two-stage MAC stand-in feeding the result inputs.
`timescale 1ns/1ps
module tb_mac_seq_ctrl;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             pause = 1'b0;
    logic             req_valid = 1'b0;
    logic             req_ready;
    logic [2:0]       req_op = 3'd0;
    logic             req_sgn1 = 1'b0;
    logic             req_sgn2 = 1'b0;
    logic [31:0]      req_rs1 = 32'd0;
    logic [31:0]      req_rs2 = 32'd0;
    logic [4:0]       req_tag = 5'd0;
    logic             rsp_valid;
    logic             rsp_ready = 1'b1;
    logic [31:0]      rsp_lo, rsp_hi;
    logic [4:0]       rsp_tag;
    logic             rsp_err;
    logic             mac_pause, mac_mul_en, mac_low, mac_high;
    logic [32:0]      mac_din1, mac_din2;
    logic [31:0]      mac_dlout, mac_dhout;
    logic             mac_vhdout;
    logic [CNT_W-1:0] perf_ops, perf_stalls;

    mac_seq_ctrl #(.CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .pause(pause),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_sgn1(req_sgn1), .req_sgn2(req_sgn2), .req_rs1(req_rs1), .req_rs2(req_rs2),
        .req_tag(req_tag),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_lo(rsp_lo), .rsp_hi(rsp_hi),
        .rsp_tag(rsp_tag), .rsp_err(rsp_err),
        .mac_pause(mac_pause), .mac_mul_en(mac_mul_en), .mac_low(mac_low), .mac_high(mac_high),
        .mac_din1(mac_din1), .mac_din2(mac_din2),
        .mac_dlout(mac_dlout), .mac_dhout(mac_dhout), .mac_vhdout(mac_vhdout),
        .perf_ops(perf_ops), .perf_stalls(perf_stalls)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- MAC stand-in: low half same cycle, high half registered ----------------
    logic signed [65:0] mac_prod;
    logic [63:0]        mac_acc_q, mac_sum;
    logic [31:0]        mac_dh_q;
    logic               mac_vh_q;

    assign mac_prod   = $signed(mac_din1) * $signed(mac_din2);
    assign mac_sum    = (mac_mul_en ? 64'd0 : mac_acc_q) + mac_prod[63:0];
    assign mac_dlout  = mac_sum[31:0];
    assign mac_dhout  = mac_dh_q;
    assign mac_vhdout = mac_vh_q;

    always @(posedge clk) begin
        if (!reset) begin
            mac_acc_q <= 64'd0;
            mac_dh_q  <= 32'd0;
            mac_vh_q  <= 1'b0;
        end else if (!mac_pause) begin
            if (mac_low) mac_acc_q[31:0] <= mac_sum[31:0];
            if (mac_high) begin
                mac_acc_q[63:32] <= mac_sum[63:32];
                mac_dh_q         <= mac_sum[63:32];
            end
            mac_vh_q <= mac_high;
        end
    end

    // ---------------- checking ----------------
    int n_pass = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [2:0] exp_ctl(input logic [2:0] op);
        case (op)
            3'd0, 3'd4: return 3'b111;
            3'd1:       return 3'b010;
            3'd2:       return 3'b001;
            3'd3, 3'd5: return 3'b011;
            default:    return 3'b000;
        endcase
    endfunction

    // Reference: a 64-bit accumulator updated by each op's arithmetic meaning.
    logic [63:0] ref_acc = 64'd0;
    int unsigned ref_ops = 0;

    function automatic logic [64:0] ref_exec(input logic [2:0] op, input logic s1, input logic s2,
                                             input logic [31:0] a, input logic [31:0] b);
        logic signed [32:0] x, y;
        logic signed [65:0] p;
        logic [63:0] pr, sum;
        x = {s1 & a[31], a};
        y = {s2 & b[31], b};
        p = x * y;
        pr = p[63:0];
        sum = ref_acc + pr;
        case (op)
            3'd0: begin ref_acc = pr; return {1'b0, pr}; end
            3'd1: begin ref_acc[31:0] = sum[31:0]; return {1'b0, 32'd0, sum[31:0]}; end
            3'd2: begin ref_acc[63:32] = sum[63:32]; return {1'b0, sum[63:32], 32'd0}; end
            3'd3: begin ref_acc = sum; return {1'b0, sum}; end
            3'd4: begin ref_acc = 64'd0; return 65'd0; end
            3'd5: return {1'b0, ref_acc};
            default: return {1'b1, 64'd0};
        endcase
    endfunction

    // Scoreboard: {err, tag, hi, lo} expected per accepted request, in order.
    typedef logic [69:0] rsp_t;
    rsp_t        exp_q[$];
    int unsigned strb_cnt = 0;
    logic        prev_hold = 1'b0;
    rsp_t        prev_rsp = '0;

    always @(negedge clk) begin : monitor
        logic [64:0] r;
        rsp_t cur;
        cur = {rsp_err, rsp_tag, rsp_hi, rsp_lo};
        strb_cnt += int'(mac_mul_en | mac_low | mac_high);
        if (!reset) begin
            exp_q.delete();
            ref_acc = 64'd0;
            ref_ops = 0;
            prev_hold = 1'b0;
        end else begin
            if (req_valid && req_ready) begin
                r = ref_exec(req_op, req_sgn1, req_sgn2, req_rs1, req_rs2);
                exp_q.push_back({r[64], req_tag, r[63:0]});
                if (req_op <= 3'd5) ref_ops++;
                check("ctl_accept", {mac_mul_en, mac_low, mac_high}, exp_ctl(req_op));
            end else begin
                check("ctl_idle", {mac_mul_en, mac_low, mac_high}, 3'b000);
            end
            if (prev_hold) check("rsp_hold", {rsp_valid, cur}, {1'b1, prev_rsp});
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    n_total++;
                    $display("FAIL rsp_spurious: got 0x%0h, expected no response", cur);
                end else begin
                    check("rsp_data", cur, exp_q.pop_front());
                end
            end
            prev_hold = rsp_valid & ~rsp_ready;
            prev_rsp  = cur;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        req_valid = 1'b0;
        req_op    = 3'd0;
        req_sgn1  = 1'b0;
        req_sgn2  = 1'b0;
        req_rs1   = 32'd0;
        req_rs2   = 32'd0;
        req_tag   = 5'd0;
    endtask

    task automatic drive_req(input logic [2:0] op, input logic s1, input logic s2,
                             input logic [31:0] a, input logic [31:0] b, input logic [4:0] tag);
        req_valid = 1'b1;
        req_op    = op;
        req_sgn1  = s1;
        req_sgn2  = s2;
        req_rs1   = a;
        req_rs2   = b;
        req_tag   = tag;
    endtask

    task automatic check_quiet(input string name);
        check({name, "_rsp"}, {rsp_valid, rsp_err, rsp_tag, rsp_hi, rsp_lo}, 72'd0);
        check({name, "_mac"}, {mac_pause, mac_mul_en, mac_low, mac_high, mac_din1, mac_din2}, 72'd0);
        check({name, "_perf"}, {perf_ops, perf_stalls}, 72'd0);
        check({name, "_ready"}, req_ready, 1'b1);
    endtask

    task automatic check_rsp(input string name, input logic [4:0] tag, input logic [31:0] lo,
                             input logic [31:0] hi, input logic err);
        check(name, {rsp_valid, rsp_err, rsp_tag, rsp_hi, rsp_lo}, {1'b1, err, tag, hi, lo});
    endtask

    function automatic logic [31:0] rand_opnd();
        case ($urandom_range(0, 4))
            0: return 32'h0000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h7FFF_FFFF;
            default: return $urandom();
        endcase
    endfunction

    typedef struct packed {
        logic [2:0]  op;
        logic        s1;
        logic        s2;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  tag;
        logic [31:0] lo;
        logic [31:0] hi;
        logic        err;
    } vec_t;

    vec_t vecs[13];

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int unsigned s0;
        logic [32:0] d1, d2;

        vecs[0]  = '{3'd0, 1'b1, 1'b1, 32'hFFFFFFFD, 32'd5,        5'd1,  32'hFFFFFFF1, 32'hFFFFFFFF, 1'b0};
        vecs[1]  = '{3'd3, 1'b1, 1'b1, 32'd2,        32'd3,        5'd2,  32'hFFFFFFF7, 32'hFFFFFFFF, 1'b0};
        vecs[2]  = '{3'd0, 1'b0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3,  32'h00000001, 32'hFFFFFFFE, 1'b0};
        vecs[3]  = '{3'd0, 1'b1, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd4,  32'h00000001, 32'h00000000, 1'b0};
        vecs[4]  = '{3'd5, 1'b1, 1'b1, 32'd1234,     32'd5678,     5'd5,  32'h00000001, 32'h00000000, 1'b0};
        vecs[5]  = '{3'd3, 1'b0, 1'b0, 32'h00010000, 32'h00010000, 5'd6,  32'h00000001, 32'h00000001, 1'b0};
        vecs[6]  = '{3'd1, 1'b0, 1'b0, 32'd2,        32'd3,        5'd7,  32'h00000007, 32'h00000000, 1'b0};
        vecs[7]  = '{3'd2, 1'b1, 1'b0, 32'hFFFFFFFF, 32'd1,        5'd8,  32'h00000000, 32'h00000001, 1'b0};
        vecs[8]  = '{3'd5, 1'b0, 1'b0, 32'd0,        32'd0,        5'd9,  32'h00000007, 32'h00000001, 1'b0};
        vecs[9]  = '{3'd4, 1'b0, 1'b0, 32'd9,        32'd9,        5'd10, 32'h00000000, 32'h00000000, 1'b0};
        vecs[10] = '{3'd0, 1'b1, 1'b1, 32'h80000000, 32'h80000000, 5'd11, 32'h00000000, 32'h40000000, 1'b0};
        vecs[11] = '{3'd7, 1'b1, 1'b1, 32'd3,        32'd4,        5'd12, 32'h00000000, 32'h00000000, 1'b1};
        vecs[12] = '{3'd5, 1'b0, 1'b0, 32'd0,        32'd0,        5'd13, 32'h00000000, 32'h40000000, 1'b0};

        // ---------------- reset ----------------
        #1 reset = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_quiet("reset");
        next_cycle();
        reset = 1'b1;

        // ---------------- vector table, one op at a time ----------------
        for (int i = 0; i < 13; i++) begin
            next_cycle();
            drive_req(vecs[i].op, vecs[i].s1, vecs[i].s2, vecs[i].a, vecs[i].b, vecs[i].tag);
            @(negedge clk);
            d1 = (vecs[i].op == 3'd4 || vecs[i].op == 3'd5) ? 33'd0 : {vecs[i].s1 & vecs[i].a[31], vecs[i].a};
            d2 = (vecs[i].op == 3'd4 || vecs[i].op == 3'd5) ? 33'd0 : {vecs[i].s2 & vecs[i].b[31], vecs[i].b};
            check($sformatf("tbl%0d_din", i), {req_ready, mac_din1, mac_din2}, {1'b1, d1, d2});
            next_cycle();
            drive_idle();
            next_cycle();
            @(negedge clk);
            check_rsp($sformatf("tbl%0d_rsp", i), vecs[i].tag, vecs[i].lo, vecs[i].hi, vecs[i].err);
        end

        // ---------------- back-to-back MUL then MACLH ----------------
        next_cycle();
        drive_req(3'd0, 1'b1, 1'b1, 32'hFFFFFFFD, 32'd5, 5'd20);
        next_cycle();
        drive_req(3'd3, 1'b1, 1'b1, 32'd2, 32'd3, 5'd21);
        @(negedge clk);
        check("b2b_ready", req_ready, 1'b1);
        next_cycle();
        drive_idle();
        @(negedge clk);
        check_rsp("b2b_rsp0", 5'd20, 32'hFFFFFFF1, 32'hFFFFFFFF, 1'b0);
        next_cycle();
        @(negedge clk);
        check_rsp("b2b_rsp1", 5'd21, 32'hFFFFFFF7, 32'hFFFFFFFF, 1'b0);

        // ---------------- backpressure with two ops in flight ----------------
        next_cycle();
        reset = 1'b0;
        next_cycle();
        next_cycle();
        reset = 1'b1;
        rsp_ready = 1'b0;
        next_cycle();
        drive_req(3'd0, 1'b1, 1'b1, 32'hFFFFFF9C, 32'd4, 5'd1);
        next_cycle();
        drive_req(3'd3, 1'b1, 1'b1, 32'd5, 32'd6, 5'd2);
        @(negedge clk);
        check("bp_ready_t1", req_ready, 1'b1);
        next_cycle();
        drive_idle();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("bp_stall%0d", k), {mac_pause, req_ready, rsp_valid}, 3'b101);
            if (k < 2) next_cycle();
        end
        next_cycle();
        rsp_ready = 1'b1;
        @(negedge clk);
        check_rsp("bp_rsp0", 5'd1, 32'hFFFFFE70, 32'hFFFFFFFF, 1'b0);
        next_cycle();
        @(negedge clk);
        check_rsp("bp_rsp1", 5'd2, 32'hFFFFFE8E, 32'hFFFFFFFF, 1'b0);
`ifdef MAC_SEQ_PERF_EN
        check("bp_perf_stalls", perf_stalls, 16'd3);
`else
        check("bp_perf_stalls", perf_stalls, 16'd0);
`endif

        // ---------------- pause during S2 of MUL 7x9 ----------------
        s0 = strb_cnt;
        next_cycle();
        drive_req(3'd0, 1'b0, 1'b0, 32'd7, 32'd9, 5'd5);
        next_cycle();
        drive_idle();
        pause = 1'b1;
        @(negedge clk);
        check("pz_frozen", {mac_pause, req_ready, rsp_valid, mac_mul_en, mac_low, mac_high}, 6'b100000);
        next_cycle();
        pause = 1'b0;
        @(negedge clk);
        check("pz_late", rsp_valid, 1'b0);
        next_cycle();
        @(negedge clk);
        check_rsp("pz_rsp", 5'd5, 32'd63, 32'd0, 1'b0);
        check("pz_strobes", strb_cnt - s0, 32'd1);
        next_cycle();
        drive_req(3'd5, 1'b0, 1'b0, 32'd0, 32'd0, 5'd6);
        next_cycle();
        drive_idle();
        next_cycle();
        @(negedge clk);
        check_rsp("pz_read", 5'd6, 32'd63, 32'd0, 1'b0);
        check("pz_strobes2", strb_cnt - s0, 32'd2);

        // ---------------- reserved op, then reset mid-stream ----------------
        next_cycle();
        drive_req(3'd6, 1'b1, 1'b1, 32'd5, 32'd5, 5'd7);
        @(negedge clk);
        check("rsv_ctl", {mac_mul_en, mac_low, mac_high}, 3'b000);
        next_cycle();
        drive_idle();
        next_cycle();
        @(negedge clk);
        check_rsp("rsv_rsp", 5'd7, 32'd0, 32'd0, 1'b1);
        next_cycle();
        drive_req(3'd0, 1'b0, 1'b0, 32'd2, 32'd2, 5'd8);
        next_cycle();
        drive_idle();
        reset = 1'b0;
        @(negedge clk);
        check_quiet("midrst");
        next_cycle();
        next_cycle();
        reset = 1'b1;
        @(negedge clk);
        check_quiet("postrst");
        next_cycle();
        drive_req(3'd0, 1'b0, 1'b0, 32'd1, 32'd1, 5'd9);
        next_cycle();
        drive_idle();
        next_cycle();
        @(negedge clk);
        check_rsp("postrst_mul", 5'd9, 32'd1, 32'd0, 1'b0);

        // ---------------- randomized traffic ----------------
        for (int c = 0; c < 600; c++) begin
            next_cycle();
            pause     = ($urandom_range(0, 9) == 0);
            rsp_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 2) != 0)
                drive_req(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          rand_opnd(), rand_opnd(), 5'($urandom_range(0, 31)));
            else
                drive_idle();
        end
        next_cycle();
        drive_idle();
        pause = 1'b0;
        rsp_ready = 1'b1;
        for (int k = 0; k < 20 && exp_q.size() != 0; k++) next_cycle();
        @(negedge clk);
        check("drain_empty", 72'(exp_q.size()), 72'd0);
`ifdef MAC_SEQ_PERF_EN
        check("rand_perf_ops", perf_ops, ref_ops[CNT_W-1:0]);
`else
        check("rand_perf_ops", {perf_ops, perf_stalls}, 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
